// File: rtl/fx2_fifo_dac_reader_pkg.sv
// Shared definitions for the FX2LP slave-FIFO DAC reader: read FSM encoding,
// parameter defaults and the buffer fill margin derived from the flag-latency hold.
package fx2_fifo_dac_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_READ  = 3'd2,
        ST_HOLD1 = 3'd3,
        ST_HOLD2 = 3'd4
    } rd_state_t;

    localparam logic [1:0] EP_ADDR_DEF  = 2'b00;
    localparam logic [7:0] MIDSCALE_DEF = 8'h80;
    localparam int         HOLD_CYCLES  = 2;
    // Free slots demanded before starting a read: the word in flight plus flag-latency slack.
    localparam int         FILL_MARGIN  = HOLD_CYCLES + 2;

    function automatic logic [25:0] rate_period(input logic [25:0] div);
        return (div < 26'd2) ? 26'd1 : div;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Purpose: DEPTH x 8 sample buffer with push/pop, occupancy count and synchronous flush.
// Latency: pushed word visible on pop_dat the cycle after the push; pop_dat is combinational.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
module sample_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               push_dat,
    input  logic                     pop,
    output logic [7:0]               pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fx2_fifo_dac_reader.sv
// Purpose: pull bytes from an FX2LP OUT endpoint via slave-FIFO strobes and pace them to a DAC.
// Latency: one word per 5 IFCLK cycles from the endpoint; DAC_DATA updates the cycle after a rate slot.
// Backpressure: reads stop while EMPTYN is low or the buffer has < FILL_MARGIN free; empty slots count underruns.
module fx2_fifo_dac_reader
    import fx2_fifo_dac_reader_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] MIDSCALE = MIDSCALE_DEF,
    parameter logic [1:0] EP_ADDR  = EP_ADDR_DEF
) (
    input  logic        IFCLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [25:0] RATE_DIV,
    input  logic [7:0]  FD_IN,
    input  logic        EMPTYN,
    output logic        SLRDN,
    output logic        SLOEN,
    output logic [1:0]  FIFOADR,
    output logic        FD_OE,
    output logic [7:0]  DAC_DATA,
    output logic        DAC_STROBE,
    output logic [15:0] UNDERRUN_CNT
);

    localparam int CW = $clog2(DEPTH) + 1;

    rd_state_t     state;
    logic          fd_oe_q;
    logic          en_q;
    logic [25:0]   rate_cnt;
    logic [25:0]   period_q;
    logic [CW-1:0] buf_cnt;
    logic          buf_empty;
    logic          buf_full;
    logic [7:0]    pop_dat;
    logic          room;
    logic          start_rd;
    logic          push;
    logic          slot;
    logic          pop;

    assign FIFOADR  = EP_ADDR;
    assign room     = !buf_full && (buf_cnt <= CW'(DEPTH - FILL_MARGIN));
    assign start_rd = RESET_N && (state == ST_IDLE) && ENABLE && EMPTYN && room;
    // Release the bus one cycle early so FPGA and FX2 never drive FD together.
    assign FD_OE    = fd_oe_q && !start_rd;
    assign push     = (state == ST_READ) && ENABLE;
    assign slot     = ENABLE && (rate_cnt == '0);
    assign pop      = slot && !buf_empty;

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            SLRDN   <= 1'b1;
            SLOEN   <= 1'b1;
            fd_oe_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rd) begin
                        state   <= ST_ADDR;
                        SLOEN   <= 1'b0;
                        fd_oe_q <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    state <= ST_READ;
                    SLRDN <= 1'b0;
                end
                ST_READ: begin
                    state <= ST_HOLD1;
                    SLRDN <= 1'b1;
                end
                ST_HOLD1: state <= ST_HOLD2;
                ST_HOLD2: begin
                    state   <= ST_IDLE;
                    SLOEN   <= 1'b1;
                    fd_oe_q <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    SLRDN   <= 1'b1;
                    SLOEN   <= 1'b1;
                    fd_oe_q <= 1'b1;
                end
            endcase
        end
    end

    sample_fifo #(.DEPTH(DEPTH)) u_buf (
        .clk      (IFCLK),
        .rst_n    (RESET_N),
        .flush    (!ENABLE),
        .push     (push),
        .push_dat (FD_IN),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .count    (buf_cnt),
        .empty    (buf_empty),
        .full     (buf_full)
    );

    // Period is latched only at wrap so a RATE_DIV change never truncates a slot.
    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rate_cnt <= '0;
            period_q <= 26'd1;
        end else if (!ENABLE || (rate_cnt >= period_q - 26'd1)) begin
            rate_cnt <= '0;
            period_q <= rate_period(RATE_DIV);
        end else begin
            rate_cnt <= rate_cnt + 26'd1;
        end
    end

    // The clear on the enable edge overrides that cycle's slot, which always finds a flushed buffer.
    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en_q         <= 1'b0;
            DAC_DATA     <= MIDSCALE;
            DAC_STROBE   <= 1'b0;
            UNDERRUN_CNT <= '0;
        end else begin
            en_q <= ENABLE;
            if (!ENABLE) begin
                DAC_DATA   <= MIDSCALE;
                DAC_STROBE <= 1'b0;
            end else begin
                DAC_STROBE <= slot;
                if (pop) DAC_DATA <= pop_dat;
            end
            if (ENABLE && !en_q) begin
                UNDERRUN_CNT <= '0;
            end else if (slot && buf_empty && (UNDERRUN_CNT != 16'hFFFF)) begin
                UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fx2_fifo_dac_reader.sv
// Directed bench: FX2LP endpoint model feeding the reader, hand-computed cycle expectations.
`timescale 1ns/1ps
module tb_fx2_fifo_dac_reader;

    logic        IFCLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic [25:0] RATE_DIV;
    logic [7:0]  FD_IN;
    logic        EMPTYN;
    logic        SLRDN;
    logic        SLOEN;
    logic [1:0]  FIFOADR;
    logic        FD_OE;
    logic [7:0]  DAC_DATA;
    logic        DAC_STROBE;
    logic [15:0] UNDERRUN_CNT;

    logic        fx_clr;
    logic        fx_avail;
    logic [7:0]  fx_base;
    int          fx_limit;
    int          fx_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 IFCLK = ~IFCLK;

    fx2_fifo_dac_reader dut (
        .IFCLK        (IFCLK),
        .RESET_N      (RESET_N),
        .ENABLE       (ENABLE),
        .RATE_DIV     (RATE_DIV),
        .FD_IN        (FD_IN),
        .EMPTYN       (EMPTYN),
        .SLRDN        (SLRDN),
        .SLOEN        (SLOEN),
        .FIFOADR      (FIFOADR),
        .FD_OE        (FD_OE),
        .DAC_DATA     (DAC_DATA),
        .DAC_STROBE   (DAC_STROBE),
        .UNDERRUN_CNT (UNDERRUN_CNT)
    );

    // Endpoint model: presents word fx_base+idx, advances on each read strobe.
    assign FD_IN  = fx_base + 8'(fx_idx);
    assign EMPTYN = fx_avail && ((fx_limit == 0) || (fx_idx < fx_limit));

    always @(posedge IFCLK) begin
        if (fx_clr)      fx_idx <= 0;
        else if (!SLRDN) fx_idx <= fx_idx + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge IFCLK);
        #1;
    endtask

    initial begin
        int lows;
        int first_low;
        int sloen_low;
        int fdoe_low;

        RESET_N  = 1'b0;
        ENABLE   = 1'b0;
        RATE_DIV = 26'd8;
        fx_clr   = 1'b1;
        fx_avail = 1'b0;
        fx_base  = 8'h00;
        fx_limit = 0;
        repeat (3) tick();
        check("rst_slrdn",  SLRDN, 1);
        check("rst_sloen",  SLOEN, 1);
        check("rst_fd_oe",  FD_OE, 1);
        check("rst_fifoadr", FIFOADR, 0);
        check("rst_dac",    DAC_DATA, 8'h80);
        check("rst_strobe", DAC_STROBE, 0);
        check("rst_underrun", UNDERRUN_CNT, 0);
        RESET_N = 1'b1;
        tick();

        // Three words at RATE_DIV=8
        fx_clr = 1'b0; fx_base = 8'h10; fx_limit = 3; fx_avail = 1'b1; ENABLE = 1'b1;
        lows = 0; first_low = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!SLRDN) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
            if (i == 1) begin
                check("addr_sloen", SLOEN, 0);
                check("addr_fd_oe", FD_OE, 0);
                check("addr_slrdn", SLRDN, 1);
                check("addr_fifoadr", FIFOADR, 0);
            end
            if (i == 8)  check("t1_before_first", DAC_DATA, 8'h80);
            if (i == 9) begin
                check("t1_word0", DAC_DATA, 8'h10);
                check("t1_strobe", DAC_STROBE, 1);
            end
            if (i == 10) check("t1_strobe_off", DAC_STROBE, 0);
            if (i == 17) check("t1_word1", DAC_DATA, 8'h11);
            if (i == 25) check("t1_word2", DAC_DATA, 8'h12);
            if (i == 30) check("t1_no_underrun", UNDERRUN_CNT, 0);
            if (i == 34) begin
                check("t1_underrun_after_drain", UNDERRUN_CNT, 1);
                check("t1_hold_last", DAC_DATA, 8'h12);
            end
            if (i == 40) check("t1_underrun_40", UNDERRUN_CNT, 1);
        end
        check("t1_read_count", lows, 3);
        check("t1_first_read", first_low, 2);
        ENABLE = 1'b0; RATE_DIV = 26'd2;
        tick(); tick();
        check("dis_dac_mid", DAC_DATA, 8'h80);
        check("dis_strobe", DAC_STROBE, 0);

        // RATE_DIV=2 with continuous data: underruns and held values
        fx_clr = 1'b1; fx_base = 8'h40; fx_limit = 0;
        repeat (4) tick();
        fx_clr = 1'b0; ENABLE = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 2)  check("t2_fd_in", FD_IN, 8'h40);
            if (i == 3)  check("t2_push_pop_empty", UNDERRUN_CNT, 1);
            if (i == 5)  check("t2_word0", DAC_DATA, 8'h40);
            if (i == 7) begin
                check("t2_underrun2", UNDERRUN_CNT, 2);
                check("t2_hold0", DAC_DATA, 8'h40);
            end
            if (i == 9)  check("t2_word1", DAC_DATA, 8'h41);
            if (i == 13) begin
                check("t2_underrun4", UNDERRUN_CNT, 4);
                check("t2_hold1", DAC_DATA, 8'h41);
            end
            if (i == 15) check("t2_word2", DAC_DATA, 8'h42);
        end
        ENABLE = 1'b0; fx_avail = 1'b0; RATE_DIV = 26'd4;
        repeat (6) tick();

        // Endpoint empty throughout
        ENABLE = 1'b1;
        lows = 0; sloen_low = 0; fdoe_low = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!SLRDN) lows++;
            if (!SLOEN) sloen_low++;
            if (!FD_OE) fdoe_low++;
        end
        check("t3_slrdn_idle", lows, 0);
        check("t3_sloen_idle", sloen_low, 0);
        check("t3_fd_oe_high", fdoe_low, 0);
        check("t3_dac_mid", DAC_DATA, 8'h80);
        check("t3_underrun", UNDERRUN_CNT, 4);

        // ENABLE dropped during READ
        ENABLE = 1'b0; RATE_DIV = 26'd1; fx_avail = 1'b1;
        tick(); tick();
        ENABLE = 1'b1;
        tick();
        check("t4_addr", SLOEN, 0);
        tick();
        check("t4_read", SLRDN, 0);
        ENABLE = 1'b0;
        tick();
        check("t4_hold1", SLOEN, 0);
        tick();
        check("t4_hold2", SLOEN, 0);
        tick();
        check("t4_idle_sloen", SLOEN, 1);
        check("t4_dac_mid", DAC_DATA, 8'h80);
        fx_avail = 1'b0; RATE_DIV = 26'd0;
        tick();
        ENABLE = 1'b1;
        repeat (3) tick();
        check("t4_buffer_empty", UNDERRUN_CNT, 2);
        check("t4_dac_still_mid", DAC_DATA, 8'h80);

        // Reset asserted during HOLD1
        ENABLE = 1'b0; RATE_DIV = 26'd8; fx_avail = 1'b1;
        tick(); tick();
        ENABLE = 1'b1;
        repeat (3) tick();
        check("t5_in_hold1", SLOEN, 0);
        #2 RESET_N = 1'b0;
        #1;
        check("t5_async_sloen", SLOEN, 1);
        check("t5_async_slrdn", SLRDN, 1);
        check("t5_fd_oe", FD_OE, 1);
        check("t5_dac", DAC_DATA, 8'h80);
        check("t5_strobe", DAC_STROBE, 0);
        check("t5_underrun", UNDERRUN_CNT, 0);
        tick();
        ENABLE = 1'b0;
        tick();
        RESET_N = 1'b1;

        // Fill level with RATE_DIV=64
        RATE_DIV = 26'd64; fx_clr = 1'b1; fx_base = 8'h20; fx_limit = 0; fx_avail = 1'b1;
        tick();
        fx_clr = 1'b0;
        tick();
        ENABLE = 1'b1;
        lows = 0; sloen_low = 0;
        for (int i = 1; i <= 128; i++) begin
            tick();
            if (!SLRDN) lows++;
            if (i >= 70 && !SLOEN) sloen_low++;
            if (i == 63) check("t6_fill_reads", lows, 13);
            if (i == 64) check("t6_before_pop", DAC_DATA, 8'h80);
            if (i == 65) check("t6_first_pop", DAC_DATA, 8'h20);
        end
        check("t6_total_reads", lows, 14);
        check("t6_idles_when_full", sloen_low, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
